// File: rtl/tx_frame_serializer.sv
// Parallel-to-serial transmit serializer with a one-word pending buffer.
// Optional even parity bit per frame: define TX_FRAME_PARITY_EN.
module tx_frame_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  shift_tick,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

`ifdef TX_FRAME_PARITY_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [FW-1:0]   sreg;
  logic [FW-1:0]   pend;
  logic            pend_full;
  logic [CW-1:0]   cnt;
  logic            done_q;

  logic            accept;
  logic            last;
  logic            head;
  logic [FW-1:0]   shifted;

  // The frame is laid out so the head bit always leaves first; the
  // parity bit, when present, sits at the tail and leaves last.
  function automatic logic [FW-1:0] frame(
    input logic [DATA_WIDTH-1:0] d
  );
`ifdef TX_FRAME_PARITY_EN
    if (MSB_FIRST) return {d, ^d};
    else           return {^d, d};
`else
    return d;
`endif
  endfunction

  assign accept   = tx_valid && tx_ready;
  assign last     = (cnt == LAST);
  assign tx_ready = !pend_full;
  assign tx_busy  = (state == SHIFT);
  assign tx_done  = done_q;

  assign head = MSB_FIRST ? sreg[FW-1] : sreg[0];
  assign shifted = MSB_FIRST ? {sreg[FW-2:0], 1'b0}
                             : {1'b0, sreg[FW-1:1]};

  assign tx_out = (state == SHIFT) ? head : IDLE_LEVEL;

  // Frame sequencer: load, shift on tick, chain the next frame.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      sreg      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      cnt       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= frame(tx_data);
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_tick && last) begin
            done_q <= 1'b1;
            cnt    <= '0;
            if (pend_full) begin
              sreg      <= pend;
              pend_full <= 1'b0;
            end else if (accept) begin
              sreg <= frame(tx_data);
            end else begin
              state <= IDLE;
            end
          end else begin
            if (shift_tick) begin
              sreg <= shifted;
              cnt  <= cnt + CW'(1);
            end
            if (accept) begin
              pend      <= frame(tx_data);
              pend_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Scoreboard bench for tx_frame_serializer.
// Runs an MSB-first and an LSB-first instance from the same stimulus.
module tb_tx_frame_serializer;

  localparam int DW = 8;
`ifdef TX_FRAME_PARITY_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          shift_tick = 1'b0;
  logic [1:0]    rdy;
  logic [1:0]    busy;
  logic [1:0]    done;
  logic [1:0]    out;

  int chk_m = 0;
  int err_m = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_u
    int chk = 0;
    int err = 0;
    bit q[$];
    bit dexp = 1'b0;
    int rem;
    bit e;

    tx_frame_serializer #(
      .DATA_WIDTH(DW),
      .MSB_FIRST (g == 0),
      .IDLE_LEVEL(1'b1)
    ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (rdy[g]),
      .shift_tick(shift_tick),
      .tx_out    (out[g]),
      .tx_busy   (busy[g]),
      .tx_done   (done[g])
    );

    task automatic cmp(input string nm, input logic a, input logic x);
      chk++;
      if (a !== x) begin
        err++;
        $display("FAIL u%0d %s got %b want %b at %0t", g, nm, a, x, $time);
      end
    endtask

    // Reference: a frame is its data bits in wire order, then parity.
    task automatic push_word(input logic [DW-1:0] d);
      for (int i = 0; i < DW; i++)
        q.push_back((g == 0) ? d[DW-1-i] : d[i]);
      if (FW > DW) q.push_back(^d);
    endtask

    always @(negedge clk) begin
      if (!n_rst) begin
        q.delete();
        dexp = 1'b0;
      end else begin
        rem = q.size();
        cmp("busy", busy[g], rem != 0);
        cmp("ready", rdy[g], !(rem > FW));
        cmp("done", done[g], dexp);
        dexp = 1'b0;
        if (rem == 0) begin
          cmp("idle_out", out[g], 1'b1);
        end else if (shift_tick) begin
          e = q.pop_front();
          cmp("bit", out[g], e);
          if (q.size() % FW == 0) dexp = 1'b1;
        end else begin
          cmp("hold_out", out[g], q[0]);
        end
        if (tx_valid && rdy[g]) push_word(tx_data);
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic t, output logic acc);
    tx_valid   = v;
    tx_data    = d;
    shift_tick = t;
    acc = v && rdy[0];
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    logic acc;
    n = 0;
    while (busy != 2'b00 && n < 400) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    chk_m++;
    if (busy != 2'b00) begin
      err_m++;
      $display("FAIL drain busy got %b want 00", busy);
    end
    repeat (3) step(1'b0, '0, 1'b1, acc);
  endtask

  task automatic send_every(input logic [DW-1:0] d, input int per);
    logic acc;
    step(1'b1, d, 1'b1, acc);
    chk_m++;
    if (!acc) begin
      err_m++;
      $display("FAIL send_accept got 0 want 1");
    end
    for (int i = 0; i < FW * per + 4; i++)
      step(1'b0, '0, (i % per) == (per - 1), acc);
  endtask

  initial begin
    logic acc;
    logic hold;
    logic [DW-1:0] hd;
    int per;

    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) step(1'b0, '0, 1'b1, acc);

    send_every(8'h1E, 4);
    send_every(8'h07, 1);
    send_every(8'h03, 2);

    step(1'b1, 8'hA5, 1'b0, acc);
    repeat (3) step(1'b0, '0, 1'b1, acc);
    step(1'b1, 8'h3C, 1'b0, acc);
    drain();

    step(1'b1, 8'hA5, 1'b1, acc);
    for (int i = 0; i < FW - 1; i++) step(1'b0, '0, 1'b1, acc);
    step(1'b1, 8'hFF, 1'b1, acc);
    drain();

    hold = 1'b0;
    hd = '0;
    for (int s = 0; s < 6; s++) begin
      per = 1 + (s % 4);
      for (int c = 0; c < 400; c++) begin
        if (!hold) begin
          hold = ($urandom_range(3) == 0);
          hd = DW'($urandom);
        end
        step(hold, hd, ($urandom_range(per - 1) == 0), acc);
        if (acc) hold = 1'b0;
      end
      hold = 1'b0;
      drain();
    end

    step(1'b1, 8'h55, 1'b0, acc);
    repeat (3) step(1'b0, '0, 1'b1, acc);
    step(1'b1, 8'hAA, 1'b0, acc);
    repeat (2) step(1'b0, '0, 1'b1, acc);
    n_rst = 1'b0;
    step(1'b0, '0, 1'b1, acc);
    n_rst = 1'b1;
    repeat (2 * FW) step(1'b0, '0, 1'b1, acc);
    chk_m++;
    if (busy != 2'b00 || rdy != 2'b11 || out != 2'b11) begin
      err_m++;
      $display("FAIL post_reset busy %b rdy %b out %b want 00 11 11",
               busy, rdy, out);
    end

    $display("CHECKS %0d ERRORS %0d",
             chk_m + g_u[0].chk + g_u[1].chk,
             err_m + g_u[0].err + g_u[1].err);
    $finish;
  end

endmodule
